// File: rtl/vector_pkg.sv
// Shared types for the element-serial vector ALU: op codes, FSM states and
// the start-time legality check.
package vector_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_MIN  = 4'd5,
    OP_MAX  = 4'd6,
    OP_MUL  = 4'd7,
    OP_MACC = 4'd8,
    OP_SLL  = 4'd9
  } vec_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vec_state_e;

  // Reductions only make sense for associative ops that fold into one element.
  function automatic logic op_supported(input logic [3:0] op, input logic red);
    logic ok;
    ok = 1'b0;
    case (op)
      4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: ok = 1'b1;
      4'd1, 4'd7, 4'd8, 4'd9:             ok = !red;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/vector_elem_fu.sv
// Combinational element function unit: (op, a, b, c) -> {result, signed ovf}.
// Used for both the per-element path and the reduction accumulator path.
module vector_elem_fu
  import vector_pkg::*;
#(
  parameter int ELEN = 32
) (
  input  vec_op_e         op,
  input  logic [ELEN-1:0] a,
  input  logic [ELEN-1:0] b,
  input  logic [ELEN-1:0] c,
  output logic [ELEN-1:0] result,
  output logic            ovf
);

  localparam int SHW = $clog2(ELEN);

  logic [ELEN-1:0] sum;
  logic [ELEN-1:0] diff;
  logic [ELEN-1:0] prod;

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    prod   = a * b;
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (a[ELEN-1] == b[ELEN-1]) && (sum[ELEN-1] != a[ELEN-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[ELEN-1] != b[ELEN-1]) && (diff[ELEN-1] != a[ELEN-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MIN:  result = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  result = ($signed(a) > $signed(b)) ? a : b;
      OP_MUL:  result = prod;
      OP_MACC: result = prod + c;
      OP_SLL:  result = a << b[SHW-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vector_elem_alu.sv
// Element-serial vector execution stage: consumes one element per operand per
// accepted valid_i and emits element-wise results or a single reduction result.
module vector_elem_alu
  import vector_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [3:0]      op_i,
  input  logic            red_i,
  input  logic            valid_i,
  input  logic [ELEN-1:0] opa_i,
  input  logic [ELEN-1:0] opb_i,
  input  logic [ELEN-1:0] opc_i,
  output logic [ELEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            ovf_o,
  output logic            err_o
);

  localparam int COUNT = VLEN / ELEN;
  localparam int CW    = $clog2(COUNT) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

  vec_state_e      state_q, state_d;
  vec_op_e         op_q;
  logic            red_q;
  logic [CW-1:0]   cnt_q;
  logic [ELEN-1:0] acc_q;

  logic            start_ok;
  logic            start_bad;
  logic            accept;
  logic            last_elem;
  logic            first_elem;
  logic [ELEN-1:0] elem_res;
  logic [ELEN-1:0] acc_res;
  logic [ELEN-1:0] red_val;
  logic            elem_ovf;
  logic            acc_ovf;
  logic            step_ovf;

  vector_elem_fu #(.ELEN(ELEN)) u_elem_fu (
    .op     (op_q),
    .a      (opa_i),
    .b      (opb_i),
    .c      (opc_i),
    .result (elem_res),
    .ovf    (elem_ovf)
  );

  vector_elem_fu #(.ELEN(ELEN)) u_acc_fu (
    .op     (op_q),
    .a      (acc_q),
    .b      (elem_res),
    .c      ({ELEN{1'b0}}),
    .result (acc_res),
    .ovf    (acc_ovf)
  );

  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    accept     = 1'b0;
    last_elem  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (op_supported(op_i, red_i)) begin
            start_ok = 1'b1;
            state_d  = ST_RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (valid_i) begin
          accept = 1'b1;
          if (cnt_q == LAST_IDX) begin
            last_elem = 1'b1;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Element 0 of a reduction seeds the accumulator; later elements fold in.
  always_comb begin
    first_elem = (cnt_q == '0);
    red_val    = first_elem ? elem_res : acc_res;
    step_ovf   = elem_ovf | (red_q & ~first_elem & acc_ovf);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q           <= OP_ADD;
      red_q          <= 1'b0;
      cnt_q          <= '0;
      acc_q          <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      last_o         <= 1'b0;
      busy_o         <= 1'b0;
      ovf_o          <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      err_o          <= start_bad;
      busy_o         <= (state_d != ST_IDLE);
      result_valid_o <= 1'b0;
      last_o         <= 1'b0;
      if (start_ok) begin
        op_q  <= vec_op_e'(op_i);
        red_q <= red_i;
        cnt_q <= '0;
        acc_q <= '0;
        ovf_o <= 1'b0;
      end
      if (accept) begin
        cnt_q <= cnt_q + CW'(1);
        if (step_ovf) begin
          ovf_o <= 1'b1;
        end
        if (red_q) begin
          acc_q <= red_val;
          if (last_elem) begin
            result_o       <= red_val;
            result_valid_o <= 1'b1;
            last_o         <= 1'b1;
          end
        end else begin
          result_o       <= elem_res;
          result_valid_o <= 1'b1;
          last_o         <= last_elem;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_elem_alu.sv
// Self-checking bench for vector_elem_alu: directed scenarios then randomized
// operations compared against a plain-arithmetic reference model.
module tb_vector_elem_alu;

  localparam int ELEN  = 32;
  localparam int COUNT = 4;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  op_i;
  logic        red_i;
  logic        valid_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic [31:0] opc_i;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        last_o;
  logic        busy_o;
  logic        ovf_o;
  logic        err_o;

  int errors;
  int checks;

  logic [31:0] va [COUNT];
  logic [31:0] vb [COUNT];
  logic [31:0] vc [COUNT];

  vector_elem_alu #(.VLEN(128), .ELEN(ELEN)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .op_i           (op_i),
    .red_i          (red_i),
    .valid_i        (valid_i),
    .opa_i          (opa_i),
    .opb_i          (opb_i),
    .opc_i          (opc_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .last_o         (last_o),
    .busy_o         (busy_o),
    .ovf_o          (ovf_o),
    .err_o          (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] op, input logic red,
                               input logic vld, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] c);
    start_i = st;
    op_i    = op;
    red_i   = red;
    valid_i = vld;
    opa_i   = a;
    opb_i   = b;
    opc_i   = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics straight from the op table, using wide signed math.
  function automatic void modelOp(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] c,
                                  output logic [31:0] r, output bit o);
    longint sa, sb, s;
    logic [63:0] p;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    p  = 64'd0;
    sh = int'(b & 32'd31);
    o  = 1'b0;
    r  = 32'd0;
    case (op)
      4'd0: begin s = sa + sb; r = s[31:0]; o = (s > MAXS) || (s < MINS); end
      4'd1: begin s = sa - sb; r = s[31:0]; o = (s > MAXS) || (s < MINS); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? a : b;
      4'd6: r = (sa > sb) ? a : b;
      4'd7: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      4'd8: begin p = {32'd0, a} * {32'd0, b} + {32'd0, c}; r = p[31:0]; end
      4'd9: r = a << sh;
      default: r = 32'd0;
    endcase
  endfunction

  function automatic bit isLegal(input logic [3:0] op, input logic red);
    if (op > 4'd9) return 1'b0;
    if (!red) return 1'b1;
    return (op == 4'd0) || (op == 4'd2) || (op == 4'd3) || (op == 4'd4) ||
           (op == 4'd5) || (op == 4'd6);
  endfunction

  task automatic doOp(input logic [3:0] op, input logic red, input int gap);
    logic [31:0] r, t, acc;
    bit o, sticky;
    sticky = 1'b0;
    acc    = 32'd0;
    applyStimulus(1'b1, op, red, 1'b0, $urandom, $urandom, $urandom);
    tick();
    checkOutput("start_busy", busy_o, 1);
    checkOutput("start_ovf", ovf_o, 0);
    checkOutput("start_rvalid", result_valid_o, 0);
    for (int e = 0; e < COUNT; e++) begin
      applyStimulus(1'b0, 4'($urandom), 1'($urandom), 1'b1, va[e], vb[e], vc[e]);
      tick();
      modelOp(op, va[e], vb[e], vc[e], r, o);
      sticky = sticky | o;
      if (red) begin
        if (e == 0) begin
          acc = r;
        end else begin
          modelOp(op, acc, r, 32'd0, t, o);
          acc    = t;
          sticky = sticky | o;
        end
      end
      checkOutput("elem_rvalid", result_valid_o, red ? (e == COUNT - 1) : 1);
      checkOutput("elem_last", last_o, e == COUNT - 1);
      checkOutput("elem_busy", busy_o, 1);
      checkOutput("elem_ovf", ovf_o, sticky);
      if (!red) checkOutput("elem_result", result_o, r);
      if (red && e == COUNT - 1) checkOutput("red_result", result_o, acc);
      if (e < COUNT - 1) begin
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), 1'b0,
                        $urandom, $urandom, $urandom);
          tick();
          checkOutput("gap_rvalid", result_valid_o, 0);
          checkOutput("gap_busy", busy_o, 1);
        end
      end
    end
    // DRAIN cycle: a start and a valid here must both be ignored.
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b1, $urandom, $urandom, $urandom);
    tick();
    checkOutput("drain_busy", busy_o, 0);
    checkOutput("drain_rvalid", result_valid_o, 0);
    checkOutput("drain_last", last_o, 0);
    checkOutput("drain_ovf", ovf_o, sticky);
    checkOutput("drain_err", err_o, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic doBadStart(input logic [3:0] op, input logic red);
    applyStimulus(1'b1, op, red, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("bad_err", err_o, 1);
    checkOutput("bad_busy", busy_o, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, $urandom, $urandom, $urandom);
    tick();
    checkOutput("bad_err_pulse", err_o, 0);
    checkOutput("bad_busy2", busy_o, 0);
    checkOutput("bad_rvalid", result_valid_o, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("bad_rvalid2", result_valid_o, 0);
  endtask

  initial begin
    logic [3:0] rop;
    logic       rred;
    errors = 0;
    checks = 0;
    rst_i  = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    checkOutput("rst_result", result_o, 0);
    checkOutput("rst_rvalid", result_valid_o, 0);
    checkOutput("rst_last", last_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_ovf", ovf_o, 0);
    checkOutput("rst_err", err_o, 0);
    rst_i = 1'b0;
    tick();

    $display("[TB] ADD element-wise");
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd10, 32'd20, 32'd30, 32'd40};
    vc = '{32'd0, 32'd0, 32'd0, 32'd0};
    doOp(4'd0, 1'b0, 0);

    $display("[TB] MAX reduction");
    va = '{32'd5, -32'sd7, 32'd9, 32'd2};
    vb = '{32'd0, 32'd0, 32'd0, 32'd0};
    doOp(4'd6, 1'b1, 0);

    $display("[TB] SUB overflow then clean ADD");
    va = '{32'd7, 32'h8000_0000, 32'd3, 32'd9};
    vb = '{32'd2, 32'd1, 32'd1, 32'd4};
    doOp(4'd1, 1'b0, 0);
    va = '{32'd1, 32'd1, 32'd1, 32'd1};
    vb = '{32'd2, 32'd2, 32'd2, 32'd2};
    doOp(4'd0, 1'b0, 0);

    $display("[TB] MACC with gaps");
    va = '{32'd3, 32'd3, 32'd3, 32'd3};
    vb = '{32'd4, 32'd4, 32'd4, 32'd4};
    vc = '{32'd5, 32'd5, 32'd5, 32'd5};
    doOp(4'd8, 1'b0, 2);

    $display("[TB] unsupported starts");
    doBadStart(4'd12, 1'b0);
    doBadStart(4'd7, 1'b1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 32'd5, 32'd6, 32'd0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("mid_rst_result", result_o, 0);
    checkOutput("mid_rst_rvalid", result_valid_o, 0);
    checkOutput("mid_rst_last", last_o, 0);
    checkOutput("mid_rst_busy", busy_o, 0);
    checkOutput("mid_rst_ovf", ovf_o, 0);
    checkOutput("mid_rst_err", err_o, 0);
    tick();
    checkOutput("post_rst_rvalid", result_valid_o, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    va = '{32'd100, 32'd200, 32'd300, 32'd400};
    vb = '{32'd1, 32'd2, 32'd3, 32'd4};
    doOp(4'd0, 1'b0, 0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      rop  = 4'($urandom_range(0, 15));
      rred = 1'($urandom_range(0, 1));
      for (int e = 0; e < COUNT; e++) begin
        va[e] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        vb[e] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        vc[e] = $urandom;
      end
      if (isLegal(rop, rred)) doOp(rop, rred, $urandom_range(0, 2));
      else doBadStart(rop, rred);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
